// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 MIPS register file: round-robin over N_REQ producers
// onto the rd write port, plus the rt port when built with WB_DUAL_PORT_EN defined.
module regfile_wb_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [5*N_REQ-1:0]  req_addr,
   input  logic [32*N_REQ-1:0] req_data,
   input  logic                rt_free,
   input  logic [4:0]          dp_rtc,
   output logic [4:0]          rdc,
   output logic [31:0]         rd,
   output logic [4:0]          rtc,
   output logic [31:0]         rti,
   output logic                rtin,
   output logic [31:0]         pend
);

   localparam logic [2:0] NREQ_V = 3'(N_REQ);

   function automatic logic [31:0] reg_decode(input logic [4:0] addr);
      logic [31:0] mask;
      mask    = 32'd1 << addr;
      mask[0] = 1'b0;
      return mask;
   endfunction

   function automatic logic [1:0] wrap_idx(input logic [2:0] raw);
      logic [2:0] w;
      if (raw >= NREQ_V) begin
         w = raw - NREQ_V;
      end else begin
         w = raw;
      end
      return w[1:0];
   endfunction

   logic [1:0]       ptr_r;
   logic [N_REQ-1:0] elig_s;
   logic [N_REQ-1:0] zero_s;
   logic [N_REQ-1:0] gnt_mask_s;
   logic [1:0]       scan_idx_s;
   logic             rd_gnt_s;
   logic [1:0]       rd_idx_s;
   logic [4:0]       rd_addr_s;
   logic             rt_gnt_s;
   logic [1:0]       rt_idx_s;
   logic             second_s;
   logic             dual_ok_s;
   logic [4:0]       rdc_r;
   logic [31:0]      rd_r;
   logic             rtin_s;
   logic [4:0]       rtc_s;
   logic [31:0]      rti_s;

   // Classify each valid request as a real write or a discardable r0 write
   always_comb begin
      elig_s = '0;
      zero_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_addr[5*i +: 5] == 5'd0) begin
            zero_s[i] = req_valid[i];
         end else begin
            elig_s[i] = req_valid[i];
         end
      end
   end

   // Round-robin scan from ptr: first eligible takes rd, the second may take rt
   always_comb begin
      rd_gnt_s   = 1'b0;
      rd_idx_s   = 2'd0;
      rd_addr_s  = 5'd0;
      rt_gnt_s   = 1'b0;
      rt_idx_s   = 2'd0;
      second_s   = 1'b0;
      scan_idx_s = 2'd0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx_s = wrap_idx({1'b0, ptr_r} + 3'(k));
         if (elig_s[scan_idx_s] && !rd_gnt_s) begin
            rd_gnt_s  = 1'b1;
            rd_idx_s  = scan_idx_s;
            rd_addr_s = req_addr[5*scan_idx_s +: 5];
         end else if (elig_s[scan_idx_s] && !second_s) begin
            // Only the second eligible requester is considered; a same-address one yields
            second_s = 1'b1;
            rt_gnt_s = dual_ok_s && (req_addr[5*scan_idx_s +: 5] != rd_addr_s);
            rt_idx_s = scan_idx_s;
         end else begin
         end
      end
   end

   // One-hot view of the granted requesters
   always_comb begin
      gnt_mask_s = '0;
      if (rd_gnt_s) begin
         gnt_mask_s[rd_idx_s] = 1'b1;
      end else begin
      end
      if (rt_gnt_s) begin
         gnt_mask_s[rt_idx_s] = 1'b1;
      end else begin
      end
   end

   assign req_ready = rst ? (zero_s | gnt_mask_s) : '0;

   // Round-robin pointer and rd-port output stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= 2'd0;
         rdc_r <= 5'd0;
         rd_r  <= 32'd0;
      end else if (rd_gnt_s) begin
         ptr_r <= wrap_idx({1'b0, rd_idx_s} + 3'd1);
         rdc_r <= rd_addr_s;
         rd_r  <= req_data[32*rd_idx_s +: 32];
      end else begin
         rdc_r <= 5'd0;
         rd_r  <= 32'd0;
      end
   end

`ifdef WB_DUAL_PORT_EN
   logic        rtin_r;
   logic [4:0]  rtc_r;
   logic [31:0] rti_r;

   assign dual_ok_s = rt_free;

   // rt-port output stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rtin_r <= 1'b0;
         rtc_r  <= 5'd0;
         rti_r  <= 32'd0;
      end else if (rt_gnt_s) begin
         rtin_r <= 1'b1;
         rtc_r  <= req_addr[5*rt_idx_s +: 5];
         rti_r  <= req_data[32*rt_idx_s +: 32];
      end else begin
         rtin_r <= 1'b0;
         rtc_r  <= 5'd0;
         rti_r  <= 32'd0;
      end
   end

   assign rtin_s = rtin_r;
   assign rtc_s  = rtc_r;
   assign rti_s  = rti_r;
`else
   logic unused_s;

   assign dual_ok_s = 1'b0;
   assign unused_s  = rt_free;
   assign rtin_s    = 1'b0;
   assign rtc_s     = 5'd0;
   assign rti_s     = 32'd0;
`endif

   assign rdc  = rdc_r;
   assign rd   = rd_r;
   assign rtin = rtin_s;
   assign rti  = rti_s;
   assign rtc  = rtin_s ? rtc_s : dp_rtc;
   assign pend = reg_decode(rdc_r) | (rtin_s ? reg_decode(rtc_s) : 32'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (N_REQ=3) with a behavioural register file on its ports.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic        rt_free;
   logic [4:0]  dp_rtc;
   logic [4:0]  rdc;
   logic [31:0] rd;
   logic [4:0]  rtc;
   logic [31:0] rti;
   logic        rtin;
   logic [31:0] pend;

   logic [31:0] rf [32];
   logic        rf_clear;
   int          passes = 0;
   int          total  = 0;

   regfile_wb_arbiter #(.N_REQ(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rt_free   (rt_free),
      .dp_rtc    (dp_rtc),
      .rdc       (rdc),
      .rd        (rd),
      .rtc       (rtc),
      .rti       (rti),
      .rtin      (rtin),
      .pend      (pend)
   );

   always #5 clk = ~clk;

   // Register file: rd port every clock, rt port wins on the same address
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else begin
         if (rdc != 5'd0) rf[rdc] <= rd;
         if (rtin && rtc != 5'd0) rf[rtc] <= rti;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2);
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
   endtask

   initial begin
      rst = 1'b0; rf_clear = 1'b1; rt_free = 1'b0; dp_rtc = 5'd17;
      set_req(3'b111, 5'd3, 5'd4, 5'd7, 32'h1, 32'h2, 32'h3);
      #2;
      chk("reset_ready", 32'(req_ready), 32'h0);
      chk("reset_rdc", 32'(rdc), 32'h0);
      chk("reset_rd", rd, 32'h0);
      chk("reset_rti", rti, 32'h0);
      chk("reset_rtin", 32'(rtin), 32'h0);
      chk("reset_pend", pend, 32'h0);
      chk("reset_rtc", 32'(rtc), 32'd17);
      tick(); tick();
      rf_clear = 1'b0;
      req_valid = 3'b000;
      rst = 1'b1;
      tick();

      // single request to r5
      set_req(3'b001, 5'd5, 5'd0, 5'd0, 32'h00001234, 32'h0, 32'h0);
      #1 chk("single_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 3'b000;
      chk("single_rdc", 32'(rdc), 32'd5);
      chk("single_rd", rd, 32'h00001234);
      chk("single_rtin", 32'(rtin), 32'h0);
      chk("single_pend", pend, 32'h00000020);
      tick();
      chk("single_idle_rdc", 32'(rdc), 32'h0);
      chk("single_idle_pend", pend, 32'h0);
      chk("single_rf5", rf[5], 32'h00001234);

      // req2 alone wraps the pointer back to 0
      set_req(3'b100, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0000A0A0);
      #1 chk("wrap_ready", 32'(req_ready), 32'h4);
      tick(); req_valid = 3'b000;
      chk("wrap_rdc", 32'(rdc), 32'd10);
      chk("wrap_pend", pend, 32'h00000400);
      tick();

      // three requesters to r3/r4/r7 with rt_free
      rt_free = 1'b1;
      set_req(3'b111, 5'd3, 5'd4, 5'd7, 32'h33, 32'h44, 32'h77);
`ifdef WB_DUAL_PORT_EN
      #1 chk("three_ready1", 32'(req_ready), 32'h3);
      tick(); req_valid = 3'b100;
      #1;
      chk("three_rdc1", 32'(rdc), 32'd3);
      chk("three_rtin1", 32'(rtin), 32'h1);
      chk("three_rtc1", 32'(rtc), 32'd4);
      chk("three_rti1", rti, 32'h44);
      chk("three_pend1", pend, 32'h00000018);
      chk("three_ready2", 32'(req_ready), 32'h4);
      tick(); req_valid = 3'b000;
      chk("three_rdc2", 32'(rdc), 32'd7);
      chk("three_rtin2", 32'(rtin), 32'h0);
      chk("three_pend2", pend, 32'h00000080);
`else
      #1 chk("three_ready1", 32'(req_ready), 32'h1);
      tick(); req_valid = 3'b110;
      #1;
      chk("three_rdc1", 32'(rdc), 32'd3);
      chk("three_rtin1", 32'(rtin), 32'h0);
      chk("three_pend1", pend, 32'h00000008);
      chk("three_ready2", 32'(req_ready), 32'h2);
      tick(); req_valid = 3'b100;
      #1;
      chk("three_rdc2", 32'(rdc), 32'd4);
      chk("three_ready3", 32'(req_ready), 32'h4);
      tick(); req_valid = 3'b000;
      chk("three_rdc3", 32'(rdc), 32'd7);
      chk("three_rtc_dp", 32'(rtc), 32'd17);
`endif
      tick();
      chk("three_rf3", rf[3], 32'h33);
      chk("three_rf4", rf[4], 32'h44);
      chk("three_rf7", rf[7], 32'h77);

      // same destination r9 from req0 and req1
      set_req(3'b011, 5'd9, 5'd9, 5'd0, 32'hA, 32'hB, 32'h0);
      #1 chk("same_ready1", 32'(req_ready), 32'h1);
      tick(); req_valid = 3'b010;
      #1;
      chk("same_rdc1", 32'(rdc), 32'd9);
      chk("same_rd1", rd, 32'hA);
      chk("same_rtin1", 32'(rtin), 32'h0);
      chk("same_ready2", 32'(req_ready), 32'h2);
      tick(); req_valid = 3'b000;
      chk("same_rd2", rd, 32'hB);
      tick();
      chk("same_rf9", rf[9], 32'hB);

      // zero address is acknowledged and dropped
      set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'h0);
      #1 chk("zero_ready", 32'(req_ready), 32'h2);
      tick(); req_valid = 3'b000;
      chk("zero_rdc", 32'(rdc), 32'h0);
      chk("zero_rd", rd, 32'h0);
      chk("zero_pend", pend, 32'h0);

      // rt port busy: one grant per cycle, rtc follows dp_rtc
      rt_free = 1'b0; dp_rtc = 5'd11;
      set_req(3'b011, 5'd20, 5'd21, 5'd0, 32'h200, 32'h210, 32'h0);
      #1;
      chk("busy_ready1", 32'(req_ready), 32'h1);
      chk("busy_rtc1", 32'(rtc), 32'd11);
      tick(); req_valid = 3'b010; dp_rtc = 5'd12;
      #1;
      chk("busy_rdc1", 32'(rdc), 32'd20);
      chk("busy_rtin1", 32'(rtin), 32'h0);
      chk("busy_rtc2", 32'(rtc), 32'd12);
      chk("busy_ready2", 32'(req_ready), 32'h2);
      tick(); req_valid = 3'b000; dp_rtc = 5'd13;
      #1;
      chk("busy_rdc2", 32'(rdc), 32'd21);
      chk("busy_rtin2", 32'(rtin), 32'h0);
      chk("busy_rtc3", 32'(rtc), 32'd13);

      // reset while r12 sits in the output stage
      set_req(3'b001, 5'd12, 5'd0, 5'd0, 32'h0000C0C0, 32'h0, 32'h0);
      #1 chk("rst_ready_pre", 32'(req_ready), 32'h1);
      tick();
      set_req(3'b010, 5'd0, 5'd13, 5'd0, 32'h0, 32'h1, 32'h0);
      chk("rst_rdc_pre", 32'(rdc), 32'd12);
      chk("rst_pend_pre", pend, 32'h00001000);
      rst = 1'b0;
      #1;
      chk("rst_rdc", 32'(rdc), 32'h0);
      chk("rst_rd", rd, 32'h0);
      chk("rst_pend", pend, 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("rst_rf12", rf[12], 32'h0);
      rt_free = 1'b1;
      set_req(3'b101, 5'd13, 5'd0, 5'd14, 32'h0000D0D0, 32'h0, 32'h0000E0E0);
      rst = 1'b1;
      #1;
`ifdef WB_DUAL_PORT_EN
      chk("rst_ptr_ready", 32'(req_ready), 32'h5);
`else
      chk("rst_ptr_ready", 32'(req_ready), 32'h1);
`endif
      tick(); req_valid = 3'b000;
      chk("rst_ptr_rdc", 32'(rdc), 32'd13);
      chk("rst_ptr_rd", rd, 32'h0000D0D0);
`ifdef WB_DUAL_PORT_EN
      chk("rst_ptr_rtin", 32'(rtin), 32'h1);
      chk("rst_ptr_rtc", 32'(rtc), 32'd14);
`else
      chk("rst_ptr_rtin", 32'(rtin), 32'h0);
`endif

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
